alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle unsigned 8×8 multiply and 8÷8 divide sequencer for the CTI-8 core. It drives the shared ALU's opcode, operand, carry-in and output-enable inputs and captures the ALU result and carry every cycle. Multiply is shift-add; divide is restoring. While idle it releases the ALU bus so the main datapath can use it.

## Interface
- No parameters. Width is fixed at 8 bits.
- `clk`  in  1  Single clock. All state changes on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Request a new operation. Sampled only in IDLE.
- `op_div`  in  1  0 = multiply, 1 = divide. Sampled with `start`.
- `opa`  in  8  Multiplier or dividend.
- `opb`  in  8  Multiplicand or divisor.
- `busy`  out  1  High from the cycle after `start` is accepted until DONE inclusive.
- `done`  out  1  One-cycle pulse in DONE.
- `res_hi`  out  8  Multiply: product[15:8]. Divide: remainder.
- `res_lo`  out  8  Multiply: product[7:0]. Divide: quotient.
- `dz`  out  1  Divide-by-zero flag for the last divide.
- `alu_opcode`  out  4  Opcode driven to the ALU.
- `alu_a`  out  8  ALU A operand.
- `alu_b`  out  8  ALU B operand.
- `alu_cin`  out  1  ALU carry-in.
- `alu_oe`  out  1  ALU output enable.
- `alu_result`  in  8  Combinational ALU result.
- `alu_c`  in  1  Combinational ALU carry out.

## Operation
- States: IDLE, M_ADD, M_SHH, M_SHL, D_SHQ, D_SHR, D_SUB, DONE.
- `alu_*` outputs are a combinational decode of the state and working registers. `alu_oe` is 1 only in the M_* and D_* states. In IDLE and DONE, `alu_opcode`, `alu_a`, `alu_b` and `alu_cin` are all 0.
- **IDLE + start, multiply:**
  - hi ← 0, lo ← opa, mcand ← opb, cnt ← 0.
  - Go to M_ADD.
- **M_ADD:**
  - Drive ALU_ADD, a = hi, b = lo[0] ? mcand : 0, cin = 0.
  - Capture hi ← alu_result, cbit ← alu_c.
  - Go to M_SHH.
- **M_SHH:**
  - Drive ALU_SHR, a = hi, cin = cbit.
  - Capture hi ← alu_result, lsb ← alu_c.
  - Go to M_SHL.
- **M_SHL:**
  - Drive ALU_SHR, a = lo, cin = lsb.
  - Capture lo ← alu_result.
  - If cnt = 7, go to DONE. Otherwise cnt ← cnt+1 and go to M_ADD.
- **IDLE + start, divide, opb ≠ 0:**
  - rem ← 0, quot ← opa, dvs ← opb, cnt ← 0, dz ← 0.
  - Go to D_SHQ.
- **D_SHQ:**
  - Drive ALU_SHL, a = quot, cin = 0.
  - Capture quot ← alu_result, qc ← alu_c.
  - Go to D_SHR.
- **D_SHR:**
  - Drive ALU_SHL, a = rem, cin = qc.
  - Capture rem ← alu_result, ext ← alu_c.
  - Go to D_SUB.
- **D_SUB:**
  - Drive ALU_SUB, a = rem, b = dvs, cin = 1.
  - If ext | alu_c: rem ← alu_result and quot[0] ← 1. Otherwise rem is kept (restore).
  - If cnt = 7, go to DONE. Otherwise cnt ← cnt+1 and go to D_SHQ.
- **IDLE + start, divide, opb = 0:**
  - dz ← 1, res_lo ← 8'hFF, res_hi ← opa.
  - Go to DONE.
- **DONE:**
  - Copy the working registers into `res_hi`/`res_lo`. On a divide-by-zero they are already set.
  - `done` = 1, `busy` = 1.
  - Go to IDLE.
- `res_hi`, `res_lo` and `dz` hold their values until the DONE of the next operation. `dz` is also cleared at the start of the next divide.
- `start` outside IDLE is ignored. It is not queued. Operand changes after acceptance have no effect.
- All arithmetic is unsigned. The ALU's V and H flags are ignored.

## Timing
- `start` is accepted at edge 0.
- Multiply and divide (opb ≠ 0): 24 compute cycles (edges 1–24). `done` is high in cycle 25. Total latency 26 cycles including IDLE.
- Divide by zero: `done` is high in cycle 1.
- A new `start` can be accepted in the cycle after DONE (back in IDLE).
- Reset values: state = IDLE. `busy`, `done`, `dz`, `res_hi`, `res_lo`, `alu_oe`, `alu_opcode`, `alu_a`, `alu_b` and `alu_cin` are all 0.
- Reset asserted mid-operation aborts immediately and asynchronously. `alu_oe` drops in the same cycle and no partial result is written.
- The ALU path is combinational. Its result must settle within one cycle and is captured at the next edge.

## Structure
- Shared package `cti8_pkg` holds:
  - the 4-bit ALU opcode constants (ADD = 0, SUB = 1, SHL = 5, SHR = 6, …);
  - the sequencer state encoding.
- There is no sub-module. The block instantiates nothing. The ALU is connected at the core level, and the core muxes `alu_*` with its own decode based on `alu_oe`/`busy`.

## Test plan
- MUL opa = 200 (0xC8), opb = 150 (0x96) → `done` in cycle 25, {res_hi, res_lo} = 16'h7530, `dz` = 0.
- MUL 0xFF × 0xFF → 16'hFE01. MUL 0x00 × 0xAB → 16'h0000.
- DIV 200 ÷ 7 → `res_lo` = 0x1C, `res_hi` = 0x04. DIV 0xFF ÷ 0x01 → 0xFF r 0x00. DIV 0x05 ÷ 0x09 → 0x00 r 0x05.
- DIV 0x55 ÷ 0 → `done` in cycle 1, `dz` = 1, `res_lo` = 0xFF, `res_hi` = 0x55, `alu_oe` never asserted.
- Pulse `start` again at cycle 5 of a multiply → ignored, and the first result is unchanged.
- Drop `rst_n` at cycle 10 of a multiply → `busy`/`alu_oe`/outputs 0 immediately. A new MUL 3 × 4 after release → 16'h000C.

Source files
------------

// File: rtl/cti8_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cti8_pkg
//  Purpose  : Shared CTI-8 definitions. Holds the 4-bit ALU opcode constants
//             and the multiply/divide sequencer state encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package cti8_pkg;

    // ALU opcodes used by the sequencer; other core opcodes sit in between.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;

    // Multiply/divide sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_M_ADD = 3'd1,
        ST_M_SHH = 3'd2,
        ST_M_SHL = 3'd3,
        ST_D_SHQ = 3'd4,
        ST_D_SHR = 3'd5,
        ST_D_SUB = 3'd6,
        ST_DONE  = 3'd7
    } seq_state_t;

endpackage : cti8_pkg
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_muldiv_seq
//  Purpose  : Multi-cycle unsigned 8x8 shift-add multiply and 8/8 restoring
//             divide, executed by borrowing the shared CTI-8 ALU one step per
//             cycle. Releases the ALU (alu_oe = 0) while idle.
//  Ports    : clk, rst_n (async, active low)
//             start, op_div, opa, opb      - operation request
//             busy, done, res_hi, res_lo, dz - status and results
//             alu_opcode, alu_a, alu_b, alu_cin, alu_oe - ALU drive
//             alu_result, alu_c             - ALU response (combinational)
//  Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_seq
    import cti8_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       op_div,
    input  logic [7:0] opa,
    input  logic [7:0] opb,
    output logic       busy,
    output logic       done,
    output logic [7:0] res_hi,
    output logic [7:0] res_lo,
    output logic       dz,
    output logic [3:0] alu_opcode,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic       alu_cin,
    output logic       alu_oe,
    input  logic [7:0] alu_result,
    input  logic       alu_c
);

    // Working registers are shared between the two operations:
    //   r_hi = product high / partial remainder
    //   r_lo = multiplier-product low / dividend-quotient
    //   r_b  = multiplicand / divisor
    //   r_c  = one-bit carry handed from one step to the next
    //          (cbit, lsb, qc and ext are never live at the same time)
    seq_state_t r_state;
    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic [7:0] r_b;
    logic [2:0] r_cnt;
    logic       r_c;
    logic       r_zdiv;     // current op is a divide by zero: results preloaded
    logic       r_dz;
    logic [7:0] r_res_hi;
    logic [7:0] r_res_lo;

    assign busy   = (r_state != ST_IDLE);
    assign done   = (r_state == ST_DONE);
    assign dz     = r_dz;
    assign res_hi = r_res_hi;
    assign res_lo = r_res_lo;

    // ALU drive decode; everything is zero outside the compute states.
    always_comb begin
        alu_opcode = 4'd0;
        alu_a      = 8'd0;
        alu_b      = 8'd0;
        alu_cin    = 1'b0;
        alu_oe     = 1'b0;
        case (r_state)
            ST_M_ADD: begin
                alu_opcode = ALU_ADD;
                alu_a      = r_hi;
                alu_b      = r_lo[0] ? r_b : 8'd0;
                alu_oe     = 1'b1;
            end
            ST_M_SHH: begin
                alu_opcode = ALU_SHR;
                alu_a      = r_hi;
                alu_cin    = r_c;
                alu_oe     = 1'b1;
            end
            ST_M_SHL: begin
                alu_opcode = ALU_SHR;
                alu_a      = r_lo;
                alu_cin    = r_c;
                alu_oe     = 1'b1;
            end
            ST_D_SHQ: begin
                alu_opcode = ALU_SHL;
                alu_a      = r_lo;
                alu_oe     = 1'b1;
            end
            ST_D_SHR: begin
                alu_opcode = ALU_SHL;
                alu_a      = r_hi;
                alu_cin    = r_c;
                alu_oe     = 1'b1;
            end
            ST_D_SUB: begin
                alu_opcode = ALU_SUB;
                alu_a      = r_hi;
                alu_b      = r_b;
                alu_cin    = 1'b1;
                alu_oe     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_hi     <= 8'd0;
            r_lo     <= 8'd0;
            r_b      <= 8'd0;
            r_cnt    <= 3'd0;
            r_c      <= 1'b0;
            r_zdiv   <= 1'b0;
            r_dz     <= 1'b0;
            r_res_hi <= 8'd0;
            r_res_lo <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_hi   <= 8'd0;
                        r_lo   <= opa;
                        r_b    <= opb;
                        r_cnt  <= 3'd0;
                        r_zdiv <= 1'b0;
                        if (!op_div) begin
                            r_state <= ST_M_ADD;
                        end else if (opb != 8'd0) begin
                            r_dz    <= 1'b0;
                            r_state <= ST_D_SHQ;
                        end else begin
                            // Divide by zero skips compute; results go out now.
                            r_zdiv   <= 1'b1;
                            r_dz     <= 1'b1;
                            r_res_lo <= 8'hFF;
                            r_res_hi <= opa;
                            r_state  <= ST_DONE;
                        end
                    end
                end
                ST_M_ADD: begin
                    r_hi    <= alu_result;
                    r_c     <= alu_c;
                    r_state <= ST_M_SHH;
                end
                ST_M_SHH: begin
                    r_hi    <= alu_result;
                    r_c     <= alu_c;
                    r_state <= ST_M_SHL;
                end
                ST_M_SHL: begin
                    r_lo <= alu_result;
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= ST_M_ADD;
                    end
                end
                ST_D_SHQ: begin
                    r_lo    <= alu_result;
                    r_c     <= alu_c;
                    r_state <= ST_D_SHR;
                end
                ST_D_SHR: begin
                    r_hi    <= alu_result;
                    r_c     <= alu_c;
                    r_state <= ST_D_SUB;
                end
                ST_D_SUB: begin
                    // 9-bit remainder {ext, rem} >= divisor when either the
                    // shifted-out bit is set or the subtract did not borrow.
                    if (r_c || alu_c) begin
                        r_hi    <= alu_result;
                        r_lo[0] <= 1'b1;
                    end
                    if (r_cnt == 3'd7) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 3'd1;
                        r_state <= ST_D_SHQ;
                    end
                end
                ST_DONE: begin
                    if (!r_zdiv) begin
                        r_res_hi <= r_hi;
                        r_res_lo <= r_lo;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : alu_muldiv_seq
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_muldiv_seq
//  Purpose  : Self-checking bench for alu_muldiv_seq with a behavioural
//             CTI-8 ALU attached to the sequencer's ALU port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       op_div;
    logic [7:0] opa;
    logic [7:0] opb;
    logic       busy;
    logic       done;
    logic [7:0] res_hi;
    logic [7:0] res_lo;
    logic       dz;
    logic [3:0] alu_opcode;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic       alu_oe;
    logic [7:0] alu_result;
    logic       alu_c;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_muldiv_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_div     (op_div),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .res_hi     (res_hi),
        .res_lo     (res_lo),
        .dz         (dz),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_oe     (alu_oe),
        .alu_result (alu_result),
        .alu_c      (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU: ADD=0, SUB=1 (a + ~b + cin), SHL=5, SHR=6.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum    = 9'd0;
        alu_result = 8'd0;
        alu_c      = 1'b0;
        case (alu_opcode)
            4'd0: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                alu_result = alu_sum[7:0];
                alu_c      = alu_sum[8];
            end
            4'd1: begin
                alu_sum    = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
                alu_result = alu_sum[7:0];
                alu_c      = alu_sum[8];
            end
            4'd5: begin
                alu_result = {alu_a[6:0], alu_cin};
                alu_c      = alu_a[7];
            end
            4'd6: begin
                alu_result = {alu_cin, alu_a[7:1]};
                alu_c      = alu_a[0];
            end
            default: alu_result = alu_a & alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands.
    task automatic model(input logic d, input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] hi, output logic [7:0] lo, output logic z);
        logic [15:0] p;
        z = 1'b0;
        if (!d) begin
            p  = {8'd0, a} * {8'd0, b};
            hi = p[15:8];
            lo = p[7:0];
        end else if (b == 8'd0) begin
            hi = a;
            lo = 8'hFF;
            z  = 1'b1;
        end else begin
            hi = a % b;
            lo = a / b;
        end
    endtask

    // Issue one operation and wait for done. poke_cyc > 0 re-pulses start
    // with different operands in that cycle; it must be ignored.
    task automatic run_op(input logic d, input logic [7:0] a, input logic [7:0] b,
                          input int poke_cyc, output int cyc, output bit oe_seen);
        @(negedge clk);
        op_div = d; opa = a; opb = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        opa   = 8'($urandom);
        opb   = 8'($urandom);
        cyc     = 1;
        oe_seen = 1'b0;
        while (!done && cyc < 40) begin
            if (alu_oe) oe_seen = 1'b1;
            if (cyc == poke_cyc) begin
                op_div = ~d; opa = 8'h09; opb = 8'h02; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) cyc = -1;
        check("busy_at_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("done_pulse_len", {31'd0, done}, 32'd0);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic       d;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       z;
        int         cyc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         cyc;
        bit         oe_seen;
        logic [7:0] e_hi, e_lo;
        logic       e_z;
        logic       last_dz;

        vecs[0] = '{1'b0, 8'hC8, 8'h96, 8'h75, 8'h30, 1'b0, 25};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 25};
        vecs[2] = '{1'b0, 8'h00, 8'hAB, 8'h00, 8'h00, 1'b0, 25};
        vecs[3] = '{1'b1, 8'd200, 8'd7, 8'h04, 8'h1C, 1'b0, 25};
        vecs[4] = '{1'b1, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 25};
        vecs[5] = '{1'b1, 8'h05, 8'h09, 8'h05, 8'h00, 1'b0, 25};
        vecs[6] = '{1'b1, 8'h55, 8'h00, 8'h55, 8'hFF, 1'b1, 1};

        rst_n = 1'b0; start = 1'b0; op_div = 1'b0; opa = 8'd0; opb = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, busy},    32'd0);
        check("rst_done",   {31'd0, done},    32'd0);
        check("rst_dz",     {31'd0, dz},      32'd0);
        check("rst_res",    {16'd0, res_hi, res_lo}, 32'd0);
        check("rst_alu_oe", {31'd0, alu_oe},  32'd0);
        check("rst_alu_drv", {19'd0, alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].d, vecs[i].a, vecs[i].b, 0, cyc, oe_seen);
            check($sformatf("vec%0d_cycle", i), cyc, vecs[i].cyc);
            check($sformatf("vec%0d_res", i), {16'd0, res_hi, res_lo},
                  {16'd0, vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].z});
            check($sformatf("vec%0d_oe", i), {31'd0, oe_seen}, {31'd0, !vecs[i].z});
            check($sformatf("vec%0d_idle_drv", i),
                  {18'd0, alu_oe, alu_opcode, alu_a, alu_b, alu_cin}, 32'd0);
        end

        // start re-pulsed at cycle 5 of a multiply is ignored.
        run_op(1'b0, 8'd200, 8'd150, 5, cyc, oe_seen);
        check("poke_cycle", cyc, 25);
        check("poke_res", {16'd0, res_hi, res_lo}, 32'h7530);

        // Async reset at cycle 10 of a multiply.
        @(negedge clk);
        op_div = 1'b0; opa = 8'hAA; opb = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_oe", {31'd0, alu_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy},   32'd0);
        check("abort_oe",   {31'd0, alu_oe}, 32'd0);
        check("abort_out",  {15'd0, done, res_hi, res_lo, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 8'd3, 8'd4, 0, cyc, oe_seen);
        check("post_rst_cycle", cyc, 25);
        check("post_rst_res", {16'd0, res_hi, res_lo}, 32'h000C);

        // Randomized operations against the arithmetic model.
        last_dz = dz;
        for (int i = 0; i < 24; i++) begin
            logic       d;
            logic [7:0] a, b;
            d = 1'($urandom);
            a = 8'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            model(d, a, b, e_hi, e_lo, e_z);
            if (!d) e_z = last_dz;
            run_op(d, a, b, 0, cyc, oe_seen);
            check($sformatf("rnd%0d_cycle", i), cyc, (d && b == 8'd0) ? 1 : 25);
            check($sformatf("rnd%0d_res", i), {16'd0, res_hi, res_lo}, {16'd0, e_hi, e_lo});
            if (d) check($sformatf("rnd%0d_dz", i), {31'd0, dz}, {31'd0, e_z});
            last_dz = e_z;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_alu_muldiv_seq
`default_nettype wire
